// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and counter-width helper for the arbiter client
package arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} arb_client_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arb_client_fifo.sv
// arb_client_fifo: outgoing word buffer, no bypass, pointers wrap modulo DEPTH
module arb_client_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;

    assign rdata = mem[rp];
    assign full  = level == LVL_W'(DEPTH);
    assign empty = level == '0;

    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

endmodule

// File: rtl/arb_client.sv
// arb_client: requester side of the two-port arbiter; bursts up to BURST_MAX beats per grant
module arb_client
    import arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     req,
    input  logic                     gnt,
    output logic                     bus_valid,
    output logic [DATA_W-1:0]        bus_data,
    output logic                     bus_last,
    output logic                     starve,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int BEAT_W = cnt_w(BURST_MAX);
    localparam int WAIT_W = cnt_w(TIMEOUT);

    arb_client_state_t state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              full, empty, push;

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign bus_valid = (state == REQ || state == XFER) && gnt && !empty;
    assign bus_last  = bus_valid && ((beat_cnt + 1'b1 == BEAT_W'(BURST_MAX)) ||
                                     (level == LVL_W'(1) && !push));

    arb_client_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus_valid),
        .wdata (in_data),
        .rdata (bus_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req      <= 1'b0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state    <= REQ;
                    req      <= 1'b1;
                    wait_cnt <= '0;
                end
                REQ, XFER: if (bus_valid) begin
                    state    <= bus_last ? RELEASE : XFER;
                    req      <= !bus_last;
                    beat_cnt <= bus_last ? '0 : beat_cnt + 1'b1;
                    starve   <= 1'b0;
                end else if (state == XFER) begin
                    // preempted: keep beat_cnt so the resumed tenure finishes the same burst
                    state <= REQ;
                end else begin
                    if (wait_cnt != WAIT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) starve <= 1'b1;
                end
                RELEASE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_client.sv
// tb_arb_client: directed checks of the arbiter client against a registered-grant arbiter model
module tb_arb_client;

    logic       clk, reset, in_valid, in_ready, req, gnt, gnt_en;
    logic       bus_valid, bus_last, starve;
    logic [7:0] in_data, bus_data;
    logic [2:0] level;
    int         n_cmp = 0, n_err = 0;

    arb_client dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_last  (bus_last),
        .starve    (starve),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arbiter grant is registered, so it trails req by one cycle
    always_ff @(posedge clk) gnt <= gnt_en && req;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; gnt_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_starve", starve, 0);
        chk("rst_valid", bus_valid, 0);
        reset = 1'b0;

        // single word, grant follows req
        gnt_en = 1'b1;
        cyc(1, 8'hA1);
        cyc(0, 0); chk("t1_level", level, 1); chk("t1_req0", req, 0);
        cyc(0, 0); chk("t1_req1", req, 1); chk("t1_nv", bus_valid, 0);
        cyc(0, 0); chk("t1_valid", bus_valid, 1); chk("t1_last", bus_last, 1); chk("t1_data", bus_data, 8'hA1);
        cyc(0, 0); chk("t1_rel_req", req, 0); chk("t1_rel_gnt", gnt, 1); chk("t1_rel_valid", bus_valid, 0); chk("t1_rel_lvl", level, 0);
        cyc(0, 0); chk("t1_idle_req", req, 0);
        cyc(0, 0); chk("t1_stay_req", req, 0);

        // five words into a 4-deep FIFO, then a continuous grant
        gnt_en = 1'b0;
        cyc(1, 8'h10); cyc(1, 8'h11); cyc(1, 8'h12); cyc(1, 8'h13);
        cyc(1, 8'h14); chk("t2_full_lvl", level, 4); chk("t2_full_rdy", in_ready, 0); chk("t2_req", req, 1);
        gnt_en = 1'b1;
        cyc(1, 8'h14); chk("t2_b0", bus_data, 8'h10); chk("t2_b0v", bus_valid, 1); chk("t2_b0l", bus_last, 0); chk("t2_b0r", in_ready, 0);
        cyc(1, 8'h14); chk("t2_b1", bus_data, 8'h11); chk("t2_b1l", bus_last, 0); chk("t2_b1r", in_ready, 1);
        cyc(0, 0);     chk("t2_b2", bus_data, 8'h12); chk("t2_b2l", bus_last, 1); chk("t2_b2lvl", level, 3);
        cyc(0, 0);     chk("t2_rel_v", bus_valid, 0); chk("t2_rel_req", req, 0); chk("t2_rel_lvl", level, 2);
        cyc(0, 0);     chk("t2_idle_req", req, 0);
        cyc(0, 0);     chk("t2_rereq", req, 1); chk("t2_rereq_v", bus_valid, 0);
        cyc(0, 0);     chk("t2_b3", bus_data, 8'h13); chk("t2_b3l", bus_last, 0);
        cyc(0, 0);     chk("t2_b4", bus_data, 8'h14); chk("t2_b4l", bus_last, 1);
        cyc(0, 0);     chk("t2_end_v", bus_valid, 0); chk("t2_end_lvl", level, 0);
        cyc(0, 0); cyc(0, 0);

        // preemption mid-burst: grant withdrawn for one cycle
        cyc(1, 8'h20); cyc(1, 8'h21); cyc(1, 8'h22);
        cyc(1, 8'h23); chk("t3_b0", bus_data, 8'h20); chk("t3_b0v", bus_valid, 1); chk("t3_b0l", bus_last, 0);
        gnt_en = 1'b0;
        cyc(0, 0); chk("t3_pre_v", bus_valid, 0); chk("t3_pre_req", req, 1); chk("t3_pre_lvl", level, 3);
        gnt_en = 1'b1;
        cyc(0, 0); chk("t3_b1", bus_data, 8'h21); chk("t3_b1v", bus_valid, 1); chk("t3_b1l", bus_last, 0);
        cyc(0, 0); chk("t3_b2", bus_data, 8'h22); chk("t3_b2l", bus_last, 1); chk("t3_b2lvl", level, 2);
        cyc(0, 0); chk("t3_rel_v", bus_valid, 0); chk("t3_rel_lvl", level, 1);
        cyc(0, 0); cyc(0, 0);
        cyc(0, 0); chk("t3_b3", bus_data, 8'h23); chk("t3_b3v", bus_valid, 1); chk("t3_b3l", bus_last, 1);
        cyc(0, 0); chk("t3_end_lvl", level, 0);
        cyc(0, 0); cyc(0, 0);

        // starvation: no grant for 20 cycles in REQ
        gnt_en = 1'b0;
        cyc(1, 8'h30);
        cyc(0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0);
            chk($sformatf("t4_starve_%0d", i), starve, (i >= 16) ? 1 : 0);
        end
        gnt_en = 1'b1;
        cyc(0, 0); chk("t4_beat", bus_data, 8'h30); chk("t4_beat_v", bus_valid, 1); chk("t4_still", starve, 1);
        cyc(0, 0); chk("t4_clear", starve, 0); chk("t4_rel_v", bus_valid, 0);
        cyc(0, 0); cyc(0, 0);

        // reset during XFER with three words buffered
        gnt_en = 1'b0;
        cyc(1, 8'h40); cyc(1, 8'h41); cyc(1, 8'h42); cyc(1, 8'h43);
        cyc(0, 0); chk("t5_lvl4", level, 4);
        gnt_en = 1'b1;
        cyc(0, 0); chk("t5_b0", bus_data, 8'h40); chk("t5_b0l", bus_last, 0);
        cyc(0, 0); chk("t5_lvl3", level, 3); chk("t5_b1", bus_data, 8'h41);
        reset = 1'b1;
        cyc(0, 0); chk("t5_req", req, 0); chk("t5_lvl0", level, 0); chk("t5_starve", starve, 0);
        chk("t5_stale_gnt", gnt, 1); chk("t5_stale_v", bus_valid, 0); chk("t5_ready", in_ready, 1);
        reset = 1'b0;
        cyc(0, 0); chk("t5_after_v", bus_valid, 0); chk("t5_after_req", req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_client.md
Name: arb_client

Overview:
- Requester-side companion to the two-port grant arbiter. Buffers outgoing words, drives one `req` line and reacts to the matching `gnt` line.
- Transfers up to BURST_MAX words per grant tenure, then releases the arbiter. Flags starvation when a request stays ungranted too long.
- One instance sits on each arbiter port (port 0 = high priority, port 1 = low priority).

Parameters:
- DATA_W, 8, width of buffered and transferred words.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- BURST_MAX, 3, maximum beats transferred per grant tenure; must be at least 1.
- TIMEOUT, 15, cycles spent in REQ without `gnt` before `starve` asserts; must be at least 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers `in_data`.
- in_data  input  DATA_W  word to enqueue.
- in_ready  output  1  FIFO not full; a push occurs when `in_valid` and `in_ready` are both high.
- req  output  1  registered request to the arbiter.
- gnt  input  1  grant from the arbiter; registered there, so it lags `req` by 1 cycle.
- bus_valid  output  1  a beat is transferred this cycle.
- bus_data  output  DATA_W  FIFO head, qualified by `bus_valid`.
- bus_last  output  1  final beat of the current tenure, qualified by `bus_valid`.
- starve  output  1  sticky starvation flag.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - state = IDLE; `req`, `bus_valid`, `bus_last` and `starve` = 0.
  - `level` = 0; `in_ready` = 1, since it is combinational `!full`.
  - The wait counter and beat counter are cleared.
- Reset mid-operation drops `req` the next edge and discards all FIFO contents. Any in-flight `gnt` after reset is ignored because state is IDLE.
- FIFO behaviour:
  - No bypass: a word pushed while the FIFO is empty is first visible at the head the next cycle.
  - Push and pop in the same cycle are allowed; `level` is unchanged.
  - Pointers wrap modulo DEPTH.
- `req` is high exactly when state is REQ or XFER, and is driven from the state register.
- Pop condition: `bus_valid = (state==REQ || state==XFER) && gnt && !empty`. A pop happens on every cycle `bus_valid` is high.
- IDLE: if `!empty`, go to REQ.
- REQ:
  - If `gnt`, transfer beat 1 this cycle and set beat_cnt = 1.
  - Exit condition for the granted case, using the same last rule as XFER:
    - If beat 1 is last, go to RELEASE.
    - Otherwise go to XFER.
  - If no `gnt`, the wait counter increments and saturates at TIMEOUT; when it reaches TIMEOUT, `starve` is set.
  - The wait counter clears on entry to REQ from IDLE; it is not cleared on re-entry from XFER.
- XFER:
  - If `gnt`, transfer a beat and increment beat_cnt.
  - `bus_last` = (beat_cnt+1 == BURST_MAX) OR (`level` == 1 with no push this cycle). On a last beat, go to RELEASE.
  - If `gnt` is low, the client was preempted by the higher-priority port: no transfer; return to REQ and keep beat_cnt.
- RELEASE:
  - `req` = 0 for exactly one cycle.
  - `gnt` may still be high this cycle because of arbiter latency; it is ignored and no pop occurs.
  - Always go to IDLE, then re-request next cycle if data remains. This gives at least 2 cycles with `req` low between tenures, which lets the other port win.
- `starve` clears on the first cycle a beat is transferred; `starve` has priority clear over set.
- beat_cnt is 0 in IDLE and RELEASE; width is $clog2(BURST_MAX+1).

Decomposition:
- Package `arb_pkg`:
  - typedef enum logic [1:0] `arb_client_state_t` = {IDLE, REQ, XFER, RELEASE}.
  - Shared localparams for counter widths.
- Sub-module `arb_client_fifo` (DATA_W, DEPTH): push/pop, head data, `level`, `full`, `empty`. The FSM, counters and `starve` logic live in `arb_client`.

Test Plan:
- Reset, then push 0xA1 while the arbiter grants one cycle after `req` -> `req` rises 1 cycle after the push, `gnt` follows; `bus_valid` and `bus_last` are high with `bus_data`=0xA1; `req` is low for 2 cycles; `level` returns to 0.
- Push 5 words 0x10..0x14 with DEPTH=4 -> the 5th push is stalled (`in_ready`=0 while `level`=4). With a continuous grant, the tenures are 0x10,0x11,0x12 (last on 0x12), then RELEASE, then 0x13,0x14 (last on 0x14).
- Port-0 instance requests mid-burst of the port-1 instance -> port-1 `gnt` drops; port 1 returns to REQ with no transfer and no lost or duplicated word; it resumes and completes the remaining beats of its BURST_MAX.
- Hold `gnt`=0 for 20 cycles after `req` -> `starve` rises on the 16th cycle in REQ and stays high; it clears on the first granted beat.
- `gnt` still high during the RELEASE cycle -> no pop and `bus_valid`=0.
- Assert reset during XFER with `level`=3 -> next cycle `req`=0, `level`=0, `starve`=0; a stale `gnt` produces no `bus_valid`.
